// File: rtl/perf_pkg.sv
// Shared types and constants for the multi-channel performance monitor.
package perf_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUNNING = 2'd1,
        DONE    = 2'd2
    } perf_state_t;

    localparam int EV_CYCLE     = 0;
    localparam int EV_INSTR     = 1;
    localparam int EV_WRITE     = 2;
    localparam int EV_STALL     = 3;
    localparam int MAX_CHANNELS = 4;

    // Select-port width that stays legal when only one item exists.
    function automatic int sel_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/perf_channel_counter.sv
// One event counter with optional saturation and a sticky overflow flag.
module perf_channel_counter
    import perf_pkg::*;
#(
    parameter int COUNT_WIDTH = 32,
    parameter bit SATURATE    = 1'b1
) (
    input  logic                   clk,
    input  logic                   srst,
    input  logic                   en,
    input  logic                   ev,
    output logic [COUNT_WIDTH-1:0] count,
    output logic                   overflow
);

    logic [COUNT_WIDTH-1:0] count_q, count_d;
    logic                   ovf_q, ovf_d;

    always_comb begin
        count_d = count_q;
        ovf_d   = ovf_q;
        if (en && ev) begin
            if (&count_q) begin
                ovf_d = 1'b1;
                if (!SATURATE) begin
                    count_d = '0;
                end
            end else begin
                count_d = count_q + COUNT_WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            count_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            ovf_q   <= ovf_d;
        end
    end

    assign count    = count_q;
    assign overflow = ovf_q;

endmodule

// File: rtl/perf_monitor.sv
// PC-windowed multi-event performance monitor with a registered hex-nibble readout.
module perf_monitor
    import perf_pkg::*;
#(
    parameter int PC_WIDTH         = 12,
    parameter int START_PC         = 0,
    parameter int FINAL_PC         = 129,
    parameter int NUM_CHANNELS     = 4,
    parameter int NUMBER_OF_DIGITS = 8,
    parameter bit SATURATE         = 1'b1,
    localparam int COUNT_WIDTH     = 4 * NUMBER_OF_DIGITS,
    localparam int DIGIT_SEL_W     = sel_width(NUMBER_OF_DIGITS)
) (
    input  logic                    CLK_50,
    input  logic                    reset,
    input  logic [PC_WIDTH-1:0]     pc,
    input  logic                    write_m,
    input  logic                    clear,
    input  logic [1:0]              sel_channel,
    input  logic [DIGIT_SEL_W-1:0]  sel_digit,
    output logic [3:0]              digit,
    output logic [1:0]              state,
    output logic                    done,
    output logic [NUM_CHANNELS-1:0] overflow
);

    localparam logic [PC_WIDTH-1:0] START_V = PC_WIDTH'(START_PC);
    localparam logic [PC_WIDTH-1:0] FINAL_V = PC_WIDTH'(FINAL_PC);

    perf_state_t                                 state_q;
    logic [PC_WIDTH-1:0]                         prev_pc_q;
    logic [3:0]                                  digit_q, digit_d;
    logic [MAX_CHANNELS-1:0]                     events;
    logic                                        count_en;
    logic                                        chan_srst;
    logic [MAX_CHANNELS-1:0][COUNT_WIDTH-1:0]    counts;

    always_comb begin
        events           = '0;
        events[EV_CYCLE] = 1'b1;
        events[EV_INSTR] = (pc != prev_pc_q);
        events[EV_WRITE] = write_m;
        events[EV_STALL] = (pc == prev_pc_q);
    end

    // The start and finish cycles themselves are counted; clear suppresses both.
    always_comb begin
        count_en = 1'b0;
        if (!clear) begin
            case (state_q)
                IDLE:    count_en = (pc == START_V);
                RUNNING: count_en = 1'b1;
                default: count_en = 1'b0;
            endcase
        end
    end

    assign chan_srst = reset | clear;

    for (genvar gi = 0; gi < MAX_CHANNELS; gi++) begin : g_ch
        if (gi < NUM_CHANNELS) begin : g_on
            perf_channel_counter #(
                .COUNT_WIDTH (COUNT_WIDTH),
                .SATURATE    (SATURATE)
            ) u_cnt (
                .clk      (CLK_50),
                .srst     (chan_srst),
                .en       (count_en),
                .ev       (events[gi]),
                .count    (counts[gi]),
                .overflow (overflow[gi])
            );
        end else begin : g_off
            logic unused_ev;
            assign unused_ev  = events[gi];
            assign counts[gi] = '0;
        end
    end

    always_comb begin
        digit_d = 4'h0;
        if (int'(sel_channel) < NUM_CHANNELS && int'(sel_digit) < NUMBER_OF_DIGITS) begin
            digit_d = 4'(counts[sel_channel] >> (4 * int'(sel_digit)));
        end
    end

    always_ff @(posedge CLK_50) begin
        if (reset) begin
            state_q   <= IDLE;
            digit_q   <= 4'h0;
            prev_pc_q <= '0;
        end else begin
            prev_pc_q <= pc;
            if (clear) begin
                state_q <= IDLE;
                digit_q <= 4'h0;
            end else begin
                digit_q <= digit_d;
                case (state_q)
                    IDLE: begin
                        if (pc == START_V) begin
                            state_q <= (START_V == FINAL_V) ? DONE : RUNNING;
                        end
                    end
                    RUNNING: begin
                        if (pc == FINAL_V) begin
                            state_q <= DONE;
                        end
                    end
                    DONE:    state_q <= DONE;
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign state = state_q;
    assign done  = (state_q == DONE);
    assign digit = digit_q;

endmodule

// File: tb/tb_perf_monitor.sv
// Bench for perf_monitor: five configurations share one stimulus stream, checked per cycle against a behavioural model.
module tb_perf_monitor;

    localparam int NI = 5;
    // 0 main, 1 saturating nibble, 2 wrapping nibble, 3 three channels, 4 start==finish
    localparam int P_START [NI] = '{0, 0, 0, 0, 5};
    localparam int P_FINAL [NI] = '{129, 4095, 4095, 129, 5};
    localparam int P_NCH   [NI] = '{4, 4, 4, 3, 4};
    localparam int P_ND    [NI] = '{8, 1, 1, 8, 8};
    localparam int P_SAT   [NI] = '{1, 1, 0, 1, 1};

    logic        clk;
    logic        reset;
    logic [11:0] pc;
    logic        write_m;
    logic        clear;
    logic [1:0]  sel_channel;
    logic [2:0]  sel_digit;

    logic [3:0]  dig [NI];
    logic [1:0]  st  [NI];
    logic        dn  [NI];
    logic [3:0]  ovf [NI];
    logic [2:0]  ovf_nc3;

    int n_pass  = 0;
    int n_total = 0;
    bit chk_en  = 1'b0;

    int          m_st   [NI];
    longint      m_cnt  [NI][4];
    logic [3:0]  m_ovf  [NI];
    logic [3:0]  m_dig  [NI];
    int          m_prev [NI];

    logic [31:0] scan_v [NI][4];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    perf_monitor #(.START_PC(0), .FINAL_PC(129), .NUM_CHANNELS(4), .NUMBER_OF_DIGITS(8), .SATURATE(1'b1)) u_main (
        .CLK_50(clk), .reset(reset), .pc(pc), .write_m(write_m), .clear(clear),
        .sel_channel(sel_channel), .sel_digit(sel_digit),
        .digit(dig[0]), .state(st[0]), .done(dn[0]), .overflow(ovf[0]));

    perf_monitor #(.START_PC(0), .FINAL_PC(4095), .NUM_CHANNELS(4), .NUMBER_OF_DIGITS(1), .SATURATE(1'b1)) u_sat1 (
        .CLK_50(clk), .reset(reset), .pc(pc), .write_m(write_m), .clear(clear),
        .sel_channel(sel_channel), .sel_digit(sel_digit[0:0]),
        .digit(dig[1]), .state(st[1]), .done(dn[1]), .overflow(ovf[1]));

    perf_monitor #(.START_PC(0), .FINAL_PC(4095), .NUM_CHANNELS(4), .NUMBER_OF_DIGITS(1), .SATURATE(1'b0)) u_sat0 (
        .CLK_50(clk), .reset(reset), .pc(pc), .write_m(write_m), .clear(clear),
        .sel_channel(sel_channel), .sel_digit(sel_digit[0:0]),
        .digit(dig[2]), .state(st[2]), .done(dn[2]), .overflow(ovf[2]));

    perf_monitor #(.START_PC(0), .FINAL_PC(129), .NUM_CHANNELS(3), .NUMBER_OF_DIGITS(8), .SATURATE(1'b1)) u_nc3 (
        .CLK_50(clk), .reset(reset), .pc(pc), .write_m(write_m), .clear(clear),
        .sel_channel(sel_channel), .sel_digit(sel_digit),
        .digit(dig[3]), .state(st[3]), .done(dn[3]), .overflow(ovf_nc3));
    assign ovf[3] = {1'b0, ovf_nc3};

    perf_monitor #(.START_PC(5), .FINAL_PC(5), .NUM_CHANNELS(4), .NUMBER_OF_DIGITS(8), .SATURATE(1'b1)) u_eq (
        .CLK_50(clk), .reset(reset), .pc(pc), .write_m(write_m), .clear(clear),
        .sel_channel(sel_channel), .sel_digit(sel_digit),
        .digit(dig[4]), .state(st[4]), .done(dn[4]), .overflow(ovf[4]));

    task automatic chk(input string name, input longint got, input longint exp, input bit verbose);
        n_total++;
        if (got == exp) begin
            n_pass++;
            if (verbose) $display("[%0t] check %s got=%0h exp=%0h ok", $time, name, got, exp);
        end else begin
            $display("[%0t] FAIL %s got=%0h exp=%0h", $time, name, got, exp);
        end
    endtask

    // Model: measurement window, event rules, saturation/wrap and 1-cycle readout.
    always @(posedge clk) begin
        for (int i = 0; i < NI; i++) begin
            longint maxv;
            int     sd;
            int     p;
            bit     counted;
            maxv = (longint'(1) << (4 * P_ND[i])) - 1;
            p    = int'(pc);
            if (reset) begin
                m_st[i]   = 0;
                m_ovf[i]  = 4'h0;
                m_dig[i]  = 4'h0;
                m_prev[i] = 0;
                for (int k = 0; k < 4; k++) m_cnt[i][k] = 0;
            end else begin
                sd = (P_ND[i] == 1) ? int'(sel_digit[0]) : int'(sel_digit);
                if (int'(sel_channel) >= P_NCH[i] || sd >= P_ND[i])
                    m_dig[i] = 4'h0;
                else
                    m_dig[i] = 4'((m_cnt[i][sel_channel] >> (4 * sd)) & 15);
                if (clear) begin
                    m_st[i]  = 0;
                    m_ovf[i] = 4'h0;
                    m_dig[i] = 4'h0;
                    for (int k = 0; k < 4; k++) m_cnt[i][k] = 0;
                end else begin
                    counted = (m_st[i] == 1) || (m_st[i] == 0 && p == P_START[i]);
                    if (counted) begin
                        for (int k = 0; k < P_NCH[i]; k++) begin
                            bit ev;
                            case (k)
                                0:       ev = 1'b1;
                                1:       ev = (p != m_prev[i]);
                                2:       ev = write_m;
                                default: ev = (p == m_prev[i]);
                            endcase
                            if (ev) begin
                                if (m_cnt[i][k] == maxv) begin
                                    m_ovf[i][k] = 1'b1;
                                    if (P_SAT[i] == 0) m_cnt[i][k] = 0;
                                end else begin
                                    m_cnt[i][k] = m_cnt[i][k] + 1;
                                end
                            end
                        end
                    end
                    if (m_st[i] == 0 && p == P_START[i])
                        m_st[i] = (P_START[i] == P_FINAL[i]) ? 2 : 1;
                    else if (m_st[i] == 1 && p == P_FINAL[i])
                        m_st[i] = 2;
                end
                m_prev[i] = p;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            for (int i = 0; i < NI; i++) begin
                chk($sformatf("i%0d_state", i), longint'(st[i]), longint'(m_st[i]), 1'b0);
                chk($sformatf("i%0d_done", i), longint'(dn[i]), longint'(m_st[i] == 2), 1'b0);
                chk($sformatf("i%0d_ovf", i), longint'(ovf[i]), longint'(m_ovf[i]), 1'b0);
                chk($sformatf("i%0d_digit", i), longint'(dig[i]), longint'(m_dig[i]), 1'b0);
            end
        end
    end

    task automatic scan_all();
        for (int i = 0; i < NI; i++)
            for (int c = 0; c < 4; c++) scan_v[i][c] = '0;
        for (int c = 0; c < 4; c++) begin
            for (int d = 0; d < 8; d++) begin
                sel_channel = 2'(c);
                sel_digit   = 3'(d);
                pc          = pc + 12'd1;
                @(negedge clk);
                for (int i = 0; i < NI; i++) scan_v[i][c][4*d +: 4] = dig[i];
            end
        end
    endtask

    initial begin
        reset = 1'b1; pc = '0; write_m = 1'b0; clear = 1'b0;
        sel_channel = 2'd0; sel_digit = 3'd0;
        @(negedge clk);
        chk_en = 1'b1;
        @(negedge clk);
        chk("reset_state", longint'(st[0]), 0, 1'b1);
        chk("reset_done", longint'(dn[0]), 0, 1'b1);
        chk("reset_ovf", longint'(ovf[0]), 0, 1'b1);
        chk("reset_digit", longint'(dig[0]), 0, 1'b1);

        // Full run with write pulses, readout sweeping while live.
        for (int k = 0; k < 150; k++) begin
            reset       = 1'b0;
            pc          = 12'(k);
            write_m     = (k == 10 || k == 20 || k == 30 || k == 40 || k == 50 ||
                           k == 135 || k == 140 || k == 145);
            sel_channel = 2'((k >> 3) & 3);
            sel_digit   = 3'(k & 7);
            @(negedge clk);
            if (k == 19) begin
                chk("sat1_model_ch0", m_cnt[1][0], 15, 1'b1);
                chk("sat0_model_ch0", m_cnt[2][0], 4, 1'b1);
                chk("sat1_ovf0", longint'(ovf[1][0]), 1, 1'b1);
                chk("sat0_ovf0", longint'(ovf[2][0]), 1, 1'b1);
            end
            if (k == 128) chk("done_before_final", longint'(dn[0]), 0, 1'b1);
            if (k == 129) begin
                chk("done_after_final", longint'(dn[0]), 1, 1'b1);
                chk("model_ch0", m_cnt[0][0], 130, 1'b1);
                chk("model_ch1", m_cnt[0][1], 129, 1'b1);
                chk("model_ch3", m_cnt[0][3], 1, 1'b1);
            end
        end
        write_m = 1'b0;
        scan_all();
        chk("main_ch0", longint'(scan_v[0][0]), 130, 1'b1);
        chk("main_ch1", longint'(scan_v[0][1]), 129, 1'b1);
        chk("main_ch2", longint'(scan_v[0][2]), 5, 1'b1);
        chk("main_ch3", longint'(scan_v[0][3]), 1, 1'b1);
        chk("nc3_ch0", longint'(scan_v[3][0]), 130, 1'b1);
        chk("nc3_ch3", longint'(scan_v[3][3]), 0, 1'b1);
        chk("eq_ch0", longint'(scan_v[4][0]), 1, 1'b1);
        chk("eq_state", longint'(st[4]), 2, 1'b1);

        sel_channel = 2'd0; sel_digit = 3'd0; @(negedge clk);
        chk("rd_ch0_d0", longint'(dig[0]), 2, 1'b1);
        sel_digit = 3'd1; @(negedge clk);
        chk("rd_ch0_d1", longint'(dig[0]), 8, 1'b1);
        sel_channel = 2'd3; sel_digit = 3'd0; @(negedge clk);
        chk("rd_nc3_ch3", longint'(dig[3]), 0, 1'b1);
        chk("rd_main_ch3", longint'(dig[0]), 1, 1'b1);

        // Clear mid-run, then clear against a start condition, then restart.
        reset = 1'b1; pc = '0; @(negedge clk);
        for (int k = 0; k <= 50; k++) begin
            reset = 1'b0; pc = 12'(k); clear = (k == 50);
            sel_channel = 2'd0; sel_digit = 3'd0;
            @(negedge clk);
        end
        chk("clear_state", longint'(st[0]), 0, 1'b1);
        chk("clear_digit", longint'(dig[0]), 0, 1'b1);
        chk("clear_ovf_sat1", longint'(ovf[1]), 0, 1'b1);
        chk("clear_model_ch0", m_cnt[0][0], 0, 1'b1);
        pc = '0; clear = 1'b1; @(negedge clk);
        chk("clear_beats_start", longint'(st[0]), 0, 1'b1);
        clear = 1'b0; pc = '0; @(negedge clk);
        chk("restart_state", longint'(st[0]), 1, 1'b1);
        pc = 12'd1; @(negedge clk);
        chk("restart_ch0", longint'(dig[0]), 1, 1'b1);

        // Reset asserted while running.
        for (int k = 2; k <= 60; k++) begin
            pc = 12'(k); reset = (k == 60);
            @(negedge clk);
        end
        chk("rst_run_state", longint'(st[0]), 0, 1'b1);
        chk("rst_run_done", longint'(dn[0]), 0, 1'b1);
        chk("rst_run_ovf", longint'(ovf[0]), 0, 1'b1);
        chk("rst_run_digit", longint'(dig[0]), 0, 1'b1);
        chk("rst_run_ovf_sat0", longint'(ovf[2]), 0, 1'b1);
        reset = 1'b0;
        for (int k = 0; k < 10; k++) begin
            pc = 12'(k); sel_digit = 3'(k & 7);
            @(negedge clk);
        end

        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
